// File: rtl/dotdisp_pkg.sv
// rtl/dotdisp_pkg.sv - shared types and constants for the dot-display board
//
// Purpose: arbiter FSM state encoding, RAM data width, and the active-low
//          RAM strobe bundle with its idle/read constants and a helper that
//          builds the strobe pattern for a CPU access cycle.
// Ports:   none (package).

package dotdisp_pkg;

   localparam int DOTRAM_DW = 16;   // dot RAM word width
   localparam int WCNT_W    = 4;    // wait counter width, covers RAM_WAIT 1..15

   typedef enum logic [2:0] {
      ARB_IDLE,
      ARB_CPU_ACC,
      ARB_CPU_HOLD,
      ARB_SCAN_ACC,
      ARB_SCAN_DONE
   } arb_state_t;

   // All members active-low.
   typedef struct packed {
      logic ce;
      logic oe;
      logic wehi;
      logic welo;
   } ram_strb_t;

   localparam ram_strb_t RAM_STRB_IDLE = 4'b1111;   // chip deselected
   localparam ram_strb_t RAM_STRB_READ = 4'b0011;   // ce+oe low, no writes

   // Strobes for a CPU-owned cycle. Write strobes follow the CPU byte strobes
   // only when we_en is set, so the final access cycle and the hold phase
   // keep them high and the address stays stable past the write edge.
   function automatic ram_strb_t cpu_acc_strb(input logic rw,
                                              input logic uds,
                                              input logic lds,
                                              input logic we_en);
      ram_strb_t s;
      s    = RAM_STRB_IDLE;
      s.ce = 1'b0;
      s.oe = ~rw;
      if (!rw && we_en) begin
         s.wehi = uds;
         s.welo = lds;
      end
      return s;
   endfunction

endpackage

// File: rtl/dotram_arbiter.sv
// rtl/dotram_arbiter.sv - dot-display work RAM arbiter between the 68000 and scan-out
//
// Purpose: round-robin sharing of the dot RAM between CPU bus cycles and
//          scan fetches, with programmable wait states and DTACK generation.
// Ports:
//   CLK, RST        clock, synchronous active-high reset
//   RAMEN           active-low RAM select from the address decoder (AS-qualified)
//   RW, UDS, LDS    CPU read/write and active-low byte strobes
//   CPU_A           CPU word address
//   DTACK           active-low transfer acknowledge to the CPU
//   SCAN_REQ/SCAN_A scan fetch request (held until ack) and word address
//   SCAN_ACK        one-cycle pulse, SCAN_DATA valid in the same cycle
//   SCAN_DATA       registered RAM word for the fetcher
//   RAM_Q           RAM read data
//   RAM_A           registered RAM address
//   RAM_CE/RAM_OE   active-low chip/output enable
//   RAM_WEHI/WELO   active-low upper/lower byte write strobes
// All outputs are registered.

module dotram_arbiter
   import dotdisp_pkg::*;
#(
   parameter int ADDR_W   = 14,
   parameter int RAM_WAIT = 2
)(
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 RAMEN,
   input  logic                 RW,
   input  logic                 UDS,
   input  logic                 LDS,
   input  logic [ADDR_W-1:0]    CPU_A,
   output logic                 DTACK,
   input  logic                 SCAN_REQ,
   input  logic [ADDR_W-1:0]    SCAN_A,
   output logic                 SCAN_ACK,
   output logic [DOTRAM_DW-1:0] SCAN_DATA,
   input  logic [DOTRAM_DW-1:0] RAM_Q,
   output logic [ADDR_W-1:0]    RAM_A,
   output logic                 RAM_CE,
   output logic                 RAM_OE,
   output logic                 RAM_WEHI,
   output logic                 RAM_WELO
);

   localparam logic [WCNT_W-1:0] WAIT_INIT = WCNT_W'(RAM_WAIT);
   localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1);

   arb_state_t            state, state_d;
   logic [WCNT_W-1:0]     wcnt, wcnt_d, wcnt_dec;
   logic                  last_cpu, last_cpu_d;
   ram_strb_t             strb, strb_d;
   logic [ADDR_W-1:0]     ram_a_d;
   logic                  dtack_d;
   logic                  scan_ack_d;
   logic [DOTRAM_DW-1:0]  scan_data_d;
   logic                  creq;
   logic                  grant_cpu;
   logic                  grant_scan;

   assign creq     = ~RAMEN & (~UDS | ~LDS);
   assign wcnt_dec = wcnt - WCNT_ONE;

   // Tie goes to whoever did not win last time; last_cpu resets to 0 so the
   // CPU takes the first tie.
   assign grant_cpu  = creq & (~SCAN_REQ | ~last_cpu);
   assign grant_scan = SCAN_REQ & (~creq | last_cpu);

   always_comb begin
      state_d     = state;
      wcnt_d      = wcnt;
      last_cpu_d  = last_cpu;
      ram_a_d     = RAM_A;
      strb_d      = RAM_STRB_IDLE;
      dtack_d     = 1'b1;
      scan_ack_d  = 1'b0;
      scan_data_d = SCAN_DATA;

      case (state)
         ARB_IDLE: begin
            if (grant_cpu) begin
               state_d    = ARB_CPU_ACC;
               wcnt_d     = WAIT_INIT;
               last_cpu_d = 1'b1;
               ram_a_d    = CPU_A;
               strb_d     = cpu_acc_strb(RW, UDS, LDS, WAIT_INIT > WCNT_ONE);
            end else if (grant_scan) begin
               state_d    = ARB_SCAN_ACC;
               wcnt_d     = WAIT_INIT;
               last_cpu_d = 1'b0;
               ram_a_d    = SCAN_A;
               strb_d     = RAM_STRB_READ;
            end
         end

         ARB_CPU_ACC: begin
            if (RAMEN) begin
               // Bus cycle aborted: drop everything, never acknowledge.
               state_d = ARB_IDLE;
            end else if (wcnt == WCNT_ONE) begin
               state_d = ARB_CPU_HOLD;
               dtack_d = 1'b0;
               strb_d  = cpu_acc_strb(RW, UDS, LDS, 1'b0);
            end else begin
               wcnt_d = wcnt_dec;
               strb_d = cpu_acc_strb(RW, UDS, LDS, wcnt_dec > WCNT_ONE);
            end
         end

         ARB_CPU_HOLD: begin
            if (RAMEN) begin
               state_d = ARB_IDLE;
            end else begin
               dtack_d = 1'b0;
               strb_d  = cpu_acc_strb(RW, UDS, LDS, 1'b0);
            end
         end

         ARB_SCAN_ACC: begin
            if (wcnt == WCNT_ONE) begin
               state_d     = ARB_SCAN_DONE;
               scan_ack_d  = 1'b1;
               scan_data_d = RAM_Q;
            end else begin
               wcnt_d = wcnt_dec;
               strb_d = RAM_STRB_READ;
            end
         end

         ARB_SCAN_DONE: begin
            state_d = ARB_IDLE;
         end

         default: begin
            state_d = ARB_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= ARB_IDLE;
         wcnt      <= '0;
         last_cpu  <= 1'b0;
         RAM_A     <= '0;
         strb      <= RAM_STRB_IDLE;
         DTACK     <= 1'b1;
         SCAN_ACK  <= 1'b0;
         SCAN_DATA <= '0;
      end else begin
         state     <= state_d;
         wcnt      <= wcnt_d;
         last_cpu  <= last_cpu_d;
         RAM_A     <= ram_a_d;
         strb      <= strb_d;
         DTACK     <= dtack_d;
         SCAN_ACK  <= scan_ack_d;
         SCAN_DATA <= scan_data_d;
      end
   end

   assign RAM_CE   = strb.ce;
   assign RAM_OE   = strb.oe;
   assign RAM_WEHI = strb.wehi;
   assign RAM_WELO = strb.welo;

endmodule

// File: tb/tb_dotram_arbiter.sv
// tb/tb_dotram_arbiter.sv - self-checking bench for dotram_arbiter

module tb_dotram_arbiter;

   localparam int TB_WAIT = 2;

   logic        CLK = 1'b0;
   logic        RST;
   logic        RAMEN, RW, UDS, LDS;
   logic [13:0] CPU_A;
   logic        DTACK;
   logic        SCAN_REQ;
   logic [13:0] SCAN_A;
   logic        SCAN_ACK;
   logic [15:0] SCAN_DATA;
   logic [15:0] RAM_Q;
   logic [13:0] RAM_A;
   logic        RAM_CE, RAM_OE, RAM_WEHI, RAM_WELO;

   int n_cmp  = 0;
   int n_fail = 0;
   int dtack_lows = 0;

   dotram_arbiter #(.ADDR_W(14), .RAM_WAIT(TB_WAIT)) dut (
      .CLK(CLK), .RST(RST), .RAMEN(RAMEN), .RW(RW), .UDS(UDS), .LDS(LDS),
      .CPU_A(CPU_A), .DTACK(DTACK), .SCAN_REQ(SCAN_REQ), .SCAN_A(SCAN_A),
      .SCAN_ACK(SCAN_ACK), .SCAN_DATA(SCAN_DATA), .RAM_Q(RAM_Q), .RAM_A(RAM_A),
      .RAM_CE(RAM_CE), .RAM_OE(RAM_OE), .RAM_WEHI(RAM_WEHI), .RAM_WELO(RAM_WELO)
   );

   always #5 CLK = ~CLK;

   always @(negedge CLK)
      if (RST === 1'b0 && DTACK === 1'b0) dtack_lows++;

   // Single-wait-state configurations are read-only.
   a_no_write_at_wait1: assert property (@(posedge CLK) disable iff (RST)
      !(TB_WAIT == 1 && !RAMEN && !RW));

   // ctl = {RAMEN, RW, UDS, LDS}; exp = {DTACK, CE, OE, WEHI, WELO, SCAN_ACK}
   typedef struct {
      logic [3:0]  ctl;
      logic [13:0] ca;
      logic        sr;
      logic [13:0] sa;
      logic [15:0] q;
      logic [5:0]  exp;
      logic [13:0] a;
      logic [15:0] d;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(input logic [3:0] ctl, input logic [13:0] ca,
                               input logic sr, input logic [13:0] sa,
                               input logic [15:0] q, input logic [5:0] exp,
                               input logic [13:0] a, input logic [15:0] d);
      vec_t v;
      v.ctl = ctl; v.ca = ca; v.sr = sr; v.sa = sa; v.q = q;
      v.exp = exp; v.a = a; v.d = d;
      return v;
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", nm, act, exp);
      end
   endtask

   task automatic idle_inputs();
      RAMEN = 1'b1; RW = 1'b1; UDS = 1'b1; LDS = 1'b1; CPU_A = '0;
      SCAN_REQ = 1'b0; SCAN_A = '0; RAM_Q = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      RST = 1'b1;
      tick();
      tick();
      RST = 1'b0;
   endtask

   task automatic cpu_on(input logic rw, input logic uds, input logic lds, input logic [13:0] a);
      RAMEN = 1'b0; RW = rw; UDS = uds; LDS = lds; CPU_A = a;
   endtask

   task automatic cpu_off();
      RAMEN = 1'b1; RW = 1'b1; UDS = 1'b1; LDS = 1'b1;
   endtask

   task automatic wait_dtack(input string nm, output int n);
      n = 0;
      while (DTACK !== 1'b0 && n < 20) begin
         tick();
         n++;
      end
      chk(nm, 32'(DTACK), 32'h0);
   endtask

   task automatic wait_ack(input string nm);
      int n;
      n = 0;
      while (SCAN_ACK !== 1'b1 && n < 30) begin
         tick();
         n++;
      end
      chk(nm, 32'(SCAN_ACK), 32'h1);
   endtask

   initial begin
      int lat;
      int base;

      // CPU read 0x0123
      vq.push_back(mk(4'b0100, 14'h0123, 1'b0, 14'h0000, 16'hBEEF, 6'b100110, 14'h0123, 16'h0000));
      vq.push_back(mk(4'b0100, 14'h0123, 1'b0, 14'h0000, 16'hBEEF, 6'b100110, 14'h0123, 16'h0000));
      vq.push_back(mk(4'b0100, 14'h0123, 1'b0, 14'h0000, 16'hBEEF, 6'b000110, 14'h0123, 16'h0000));
      vq.push_back(mk(4'b0100, 14'h0123, 1'b0, 14'h0000, 16'hBEEF, 6'b000110, 14'h0123, 16'h0000));
      vq.push_back(mk(4'b1111, 14'h0123, 1'b0, 14'h0000, 16'hBEEF, 6'b111110, 14'h0123, 16'h0000));
      // CPU upper-byte write 0x0456
      vq.push_back(mk(4'b0001, 14'h0456, 1'b0, 14'h0000, 16'h0000, 6'b101010, 14'h0456, 16'h0000));
      vq.push_back(mk(4'b0001, 14'h0456, 1'b0, 14'h0000, 16'h0000, 6'b101110, 14'h0456, 16'h0000));
      vq.push_back(mk(4'b0001, 14'h0456, 1'b0, 14'h0000, 16'h0000, 6'b001110, 14'h0456, 16'h0000));
      vq.push_back(mk(4'b1111, 14'h0456, 1'b0, 14'h0000, 16'h0000, 6'b111110, 14'h0456, 16'h0000));
      // Scan fetch 0x3FFF
      vq.push_back(mk(4'b1111, 14'h0000, 1'b1, 14'h3FFF, 16'h5AA5, 6'b100110, 14'h3FFF, 16'h0000));
      vq.push_back(mk(4'b1111, 14'h0000, 1'b1, 14'h3FFF, 16'h5AA5, 6'b100110, 14'h3FFF, 16'h0000));
      vq.push_back(mk(4'b1111, 14'h0000, 1'b1, 14'h3FFF, 16'h5AA5, 6'b111111, 14'h3FFF, 16'h5AA5));
      vq.push_back(mk(4'b1111, 14'h0000, 1'b0, 14'h3FFF, 16'h5AA5, 6'b111110, 14'h3FFF, 16'h5AA5));

      do_reset();
      chk("rst_dtack", 32'(DTACK), 32'h1);
      chk("rst_strobes", 32'({RAM_CE, RAM_OE, RAM_WEHI, RAM_WELO}), 32'hF);
      chk("rst_ack", 32'(SCAN_ACK), 32'h0);
      chk("rst_data", 32'(SCAN_DATA), 32'h0);
      chk("rst_addr", 32'(RAM_A), 32'h0);

      for (int i = 0; i < vq.size(); i++) begin
         {RAMEN, RW, UDS, LDS} = vq[i].ctl;
         CPU_A = vq[i].ca; SCAN_REQ = vq[i].sr; SCAN_A = vq[i].sa; RAM_Q = vq[i].q;
         tick();
         chk($sformatf("row%0d_dtack", i), 32'(DTACK),     32'(vq[i].exp[5]));
         chk($sformatf("row%0d_ce", i),    32'(RAM_CE),    32'(vq[i].exp[4]));
         chk($sformatf("row%0d_oe", i),    32'(RAM_OE),    32'(vq[i].exp[3]));
         chk($sformatf("row%0d_wehi", i),  32'(RAM_WEHI),  32'(vq[i].exp[2]));
         chk($sformatf("row%0d_welo", i),  32'(RAM_WELO),  32'(vq[i].exp[1]));
         chk($sformatf("row%0d_ack", i),   32'(SCAN_ACK),  32'(vq[i].exp[0]));
         chk($sformatf("row%0d_addr", i),  32'(RAM_A),     32'(vq[i].a));
         chk($sformatf("row%0d_data", i),  32'(SCAN_DATA), 32'(vq[i].d));
      end

      // Round-robin on repeated ties
      do_reset();
      cpu_on(1'b1, 1'b0, 1'b0, 14'h0011);
      SCAN_REQ = 1'b1; SCAN_A = 14'h0022;
      tick();
      chk("tie1_cpu_first", 32'(RAM_A), 32'h0011);
      wait_dtack("tie1_dtack", lat);
      chk("tie1_latency", 32'(lat), 32'h2);
      cpu_off();
      tick();
      chk("tie1_release", 32'(DTACK), 32'h1);
      cpu_on(1'b1, 1'b0, 1'b0, 14'h0033);
      tick();
      chk("tie2_scan_first", 32'(RAM_A), 32'h0022);
      wait_ack("tie2_ack");
      SCAN_A = 14'h0044;
      tick();
      tick();
      chk("tie3_cpu", 32'(RAM_A), 32'h0033);
      wait_dtack("tie3_dtack", lat);
      cpu_off();
      tick();
      tick();
      chk("tie4_scan", 32'(RAM_A), 32'h0044);
      wait_ack("tie4_ack");
      SCAN_REQ = 1'b0;
      tick();

      // Reset in the middle of a write access
      do_reset();
      base = dtack_lows;
      cpu_on(1'b0, 1'b0, 1'b0, 14'h0100);
      tick();
      chk("rstw_we_active", 32'({RAM_WEHI, RAM_WELO}), 32'h0);
      RST = 1'b1;
      tick();
      RST = 1'b0;
      chk("rstw_strobes", 32'({RAM_CE, RAM_OE, RAM_WEHI, RAM_WELO}), 32'hF);
      chk("rstw_dtack", 32'(DTACK), 32'h1);
      cpu_off();
      SCAN_REQ = 1'b1; SCAN_A = 14'h0155; RAM_Q = 16'h1234;
      tick();
      chk("rstw_idle_grant", 32'(RAM_A), 32'h0155);
      chk("rstw_idle_ce", 32'(RAM_CE), 32'h0);
      wait_ack("rstw_ack");
      SCAN_REQ = 1'b0;
      tick();
      chk("rstw_no_dtack", 32'(dtack_lows - base), 32'h0);

      // RAMEN dropped in the second CPU_ACC cycle with a scan pending
      do_reset();
      base = dtack_lows;
      cpu_on(1'b1, 1'b0, 1'b0, 14'h0200);
      SCAN_REQ = 1'b1; SCAN_A = 14'h0300; RAM_Q = 16'hC0DE;
      tick();
      chk("abort_cpu_grant", 32'(RAM_A), 32'h0200);
      tick();
      cpu_off();
      tick();
      chk("abort_ce", 32'(RAM_CE), 32'h1);
      chk("abort_dtack", 32'(DTACK), 32'h1);
      tick();
      chk("abort_scan_grant", 32'(RAM_A), 32'h0300);
      chk("abort_scan_ce", 32'(RAM_CE), 32'h0);
      wait_ack("abort_ack");
      chk("abort_scan_data", 32'(SCAN_DATA), 32'hC0DE);
      SCAN_REQ = 1'b0;
      tick();
      chk("abort_no_dtack", 32'(dtack_lows - base), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/dotram_arbiter.md
# dotram_arbiter

Arbitrates the dot-display work RAM between the 68000 and the display scan-out fetcher on the dot-display board. It sits behind the CPU address decoder, which supplies the active-low `RAMEN` select. It drives the RAM chip-enable, output-enable and byte write strobes, and generates `DTACK` with programmable wait states. Requesters alternate round-robin so that neither CPU bus cycles nor scan fetches can starve.

## Interface
Parameters:
- `ADDR_W`, 14: RAM word-address width.
- `RAM_WAIT`, 2: RAM access cycles per grant; legal range 1..15.

Ports:
- `CLK` in 1: system clock.
- `RST` in 1: synchronous, active-high reset.
- `RAMEN` in 1: active-low RAM select from the address decoder; already qualified by `AS`.
- `RW` in 1: CPU read (1) / write (0).
- `UDS`, `LDS` in 1 each: active-low CPU byte strobes.
- `CPU_A` in `ADDR_W`: CPU word address (A1 upward).
- `DTACK` out 1: active-low transfer acknowledge to the CPU.
- `SCAN_REQ` in 1: scan fetch request; held high until `SCAN_ACK`.
- `SCAN_A` in `ADDR_W`: scan word address; stable while `SCAN_REQ` is high.
- `SCAN_ACK` out 1: one-cycle pulse; `SCAN_DATA` is valid in the same cycle.
- `SCAN_DATA` out 16: registered RAM word for the scan fetcher.
- `RAM_Q` in 16: RAM read data.
- `RAM_A` out `ADDR_W`: registered RAM address.
- `RAM_CE` out 1: active-low chip enable.
- `RAM_OE` out 1: active-low output enable.
- `RAM_WEHI`, `RAM_WELO` out 1 each: active-low upper/lower byte write strobes.

## Operation
- CPU request `creq` = `~RAMEN & (~UDS | ~LDS)`. Scan request = `SCAN_REQ`.
- FSM states:
  - IDLE
  - CPU_ACC: counter `wcnt` counts `RAM_WAIT`..1
  - CPU_HOLD
  - SCAN_ACC: counter `wcnt` counts `RAM_WAIT`..1
  - SCAN_DONE
- Arbitration in IDLE:
  - Only one request present: grant it.
  - Both present: grant the requester that did not win the previous grant. Flag `last_cpu` holds the winner; reset value 0, so the CPU wins the first tie.
  - Neither present: remain in IDLE.
- On grant:
  - `RAM_A` is loaded with the winner's address.
  - `wcnt` is loaded with `RAM_WAIT`.
  - `last_cpu` is updated.
- CPU_ACC:
  - `RAM_CE` = 0.
  - Read (`RW`=1): `RAM_OE` = 0.
  - Write (`RW`=0): `RAM_WEHI` = `UDS`, `RAM_WELO` = `LDS`. Strobes are registered and asserted only while `wcnt` > 1; all are high in the last CPU_ACC cycle, giving address hold.
  - When `wcnt` = 1, go to CPU_HOLD.
- CPU_HOLD:
  - `DTACK` = 0 and `RAM_CE` = 0.
  - Read: `RAM_OE` stays 0; the CPU samples `RAM_Q` directly.
  - Stay until `RAMEN` = 1, then release `DTACK` and return to IDLE.
- SCAN_ACC:
  - `RAM_CE` = 0, `RAM_OE` = 0.
  - When `wcnt` = 1, capture `RAM_Q` into `SCAN_DATA` and go to SCAN_DONE.
- SCAN_DONE: `SCAN_ACK` = 1 for exactly one cycle, then IDLE. The fetcher lowers `SCAN_REQ` or presents a new address in the cycle after `SCAN_ACK`.
- `RAMEN` rising during CPU_ACC (aborted bus cycle): write strobes deassert on the next cycle, the FSM goes to IDLE, and `DTACK` is never asserted.
- `RAM_WAIT` = 1: CPU_ACC lasts one cycle and write strobes are never asserted. This value is therefore legal for read-only use only; the bench checks with assertions that `RAM_WAIT` = 1 is never combined with CPU writes.

## Timing
- Reset values:
  - State IDLE.
  - `DTACK`, `RAM_CE`, `RAM_OE`, `RAM_WEHI`, `RAM_WELO` = 1.
  - `SCAN_ACK` = 0, `SCAN_DATA` = 0, `RAM_A` = 0, `last_cpu` = 0.
- All outputs are registered; no combinational paths from inputs to outputs.
- `RST` asserted in any state returns the FSM to IDLE with all strobes inactive on the next edge. No partial write strobe survives reset.
- CPU latency from `creq` in IDLE to `DTACK` low is `RAM_WAIT`+1 cycles.
- Scan latency from grant to `SCAN_ACK` is `RAM_WAIT`+1 cycles.
- Worst-case CPU wait is one full scan slot (`RAM_WAIT`+2 cycles) plus its own access.
- The return from CPU_HOLD to IDLE costs one cycle. A request pending at that point is arbitrated in that IDLE cycle, so back-to-back grants have one idle cycle between them.

## Structure
- Shared package `dotdisp_pkg`:
  - FSM state enum `arb_state_t`.
  - Constant `DOTRAM_DW` = 16.
  - Active-low idle constants for the strobe bundle.
- The wait counter is inline; no sub-module is needed.
- The `dotram_arbiter` top module instantiates nothing.

## Test plan
- CPU read, `RAM_WAIT`=2, `CPU_A`=0x0123, `RAM_Q`=0xBEEF:
  - `RAM_A`=0x0123 and `RAM_OE` low.
  - `DTACK` low 3 cycles after `creq`, held until `RAMEN`=1.
  - `RAM_WE*` stay high throughout.
- CPU byte write, `UDS`=0, `LDS`=1:
  - `RAM_WEHI` low for 1 cycle; `RAM_WELO` stays high.
  - Both strobes high in the cycle before `DTACK` falls.
- Simultaneous `creq` and `SCAN_REQ` after reset:
  - CPU granted first, then scan.
  - A second tie grants scan first.
  - Grant order alternates.
- Scan fetch, `SCAN_A`=0x3FFF, `RAM_Q`=0x5AA5:
  - `SCAN_ACK` is a one-cycle pulse with `SCAN_DATA`=0x5AA5.
  - `DTACK` stays high throughout.
- `RST` pulsed mid-CPU_ACC during a write:
  - All strobes high on the next cycle.
  - State IDLE; `DTACK` never asserted.
- `RAMEN` deasserted in the second CPU_ACC cycle:
  - No `DTACK`.
  - FSM returns to IDLE.
  - A pending `SCAN_REQ` is granted on the following cycle.
